// File: rtl/comparator_serial_nbit_pkg.sv
// Shared types and helpers for the serial magnitude comparator.
//   cmp_state_e : scan FSM states (IDLE, SCAN)
//   cmp_res_t   : one-hot compare result {eq, gt, lt}
//   ndig()      : number of DIGIT-wide digits in a WIDTH-bit operand
package comparator_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } cmp_state_e;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } cmp_res_t;

  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/comparator_serial_nbit_digit_compare.sv
// Combinational compare of one DIGIT-bit digit pair (unsigned).
// Ports:
//   a, b : digits to compare
//   eq   : a == b
//   gt   : a >  b   (a < b is implied by !eq && !gt)
module digit_compare #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             eq,
  output logic             gt
);

  assign eq = (a == b);
  assign gt = (a > b);

endmodule

// File: rtl/comparator_serial_nbit.sv
// Multi-cycle magnitude comparator. Operands are captured on an accepted
// start and scanned MSB-first, DIGIT bits per clock; the scan stops on the
// first differing digit. Equal operands take NDIG clocks.
// Optional feature macro: COMPARATOR_SIGNED_EN adds the signed_mode input,
// which selects two's-complement ordering for the captured operands.
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   start        : request, sampled only while busy=0
//   aa, bb       : operands, captured on accepted start
//   signed_mode  : (COMPARATOR_SIGNED_EN only) signed compare, captured on start
//   busy         : scan in progress
//   done         : one-cycle pulse, result valid from this cycle on
//   EE, GG, LL   : A==B, A>B, A<B; held until the next accepted start
module comparator_serial_nbit
  import comparator_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] aa,
  input  logic [WIDTH-1:0] bb,
`ifdef COMPARATOR_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic             EE,
  output logic             GG,
  output logic             LL
);

  localparam int NDIG  = ndig(WIDTH, DIGIT);
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG - 1);

  if (WIDTH % DIGIT != 0) begin : g_width_check
    $error("comparator_serial_nbit: WIDTH (%0d) must be a multiple of DIGIT (%0d)",
           WIDTH, DIGIT);
  end

  cmp_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  cmp_res_t         res_q, res_d;

  logic [WIDTH-1:0] a_load, b_load;
  logic             dig_eq, dig_gt;

  // Flipping both sign bits maps two's-complement order onto unsigned order,
  // so the scan itself never needs to know about signedness.
`ifdef COMPARATOR_SIGNED_EN
  logic [WIDTH-1:0] msb_flip;
  assign msb_flip = WIDTH'(signed_mode) << (WIDTH - 1);
  assign a_load   = aa ^ msb_flip;
  assign b_load   = bb ^ msb_flip;
`else
  assign a_load   = aa;
  assign b_load   = bb;
`endif

  digit_compare #(
    .DIGIT (DIGIT)
  ) u_digit_compare (
    .a  (a_q[WIDTH-1 -: DIGIT]),
    .b  (b_q[WIDTH-1 -: DIGIT]),
    .eq (dig_eq),
    .gt (dig_gt)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_load;
          b_d     = b_load;
          cnt_d   = CNT_LAST;
          res_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (!dig_eq) begin
          res_d   = '{eq: 1'b0, gt: dig_gt, lt: ~dig_gt};
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          res_d   = '{eq: 1'b1, gt: 1'b0, lt: 1'b0};
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          // Bring the next digit into the top position of both registers.
          a_d   = a_q << DIGIT;
          b_d   = b_q << DIGIT;
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  assign busy = (state_q == SCAN);
  assign done = done_q;
  assign EE   = res_q.eq;
  assign GG   = res_q.gt;
  assign LL   = res_q.lt;

endmodule

// File: tb/tb_comparator_serial_nbit.sv
// Directed bench for comparator_serial_nbit (WIDTH=16, DIGIT=2).
// Expected results are queued when a start is driven and checked when done
// pulses. Define COMPARATOR_SIGNED_EN for both files to cover signed_mode.
module tb_comparator_serial_nbit;

  localparam int WIDTH = 16;
  localparam int DIGIT = 2;
  localparam int NDIG  = WIDTH / DIGIT;
  localparam int MAX_WAIT = 20;

  typedef struct {
    logic [2:0] res;   // {EE, GG, LL}
    int         k;     // edges from start edge to done
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] aa;
  logic [WIDTH-1:0] bb;
  logic             sm;
  logic             busy;
  logic             done;
  logic             EE;
  logic             GG;
  logic             LL;

  int   n_checks;
  int   n_errors;
  exp_t sb[$];

  comparator_serial_nbit #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .aa          (aa),
    .bb          (bb),
`ifdef COMPARATOR_SIGNED_EN
    .signed_mode (sm),
`endif
    .busy        (busy),
    .done        (done),
    .EE          (EE),
    .GG          (GG),
    .LL          (LL)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: ordering from the language's own compare, latency from the
  // position of the first differing 2-bit digit counted from the MSB.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic s);
    exp_t e;
    logic [1:0] da, db;
    if (s) begin
      e.res = ($signed(a) == $signed(b)) ? 3'b100 :
              ($signed(a) >  $signed(b)) ? 3'b010 : 3'b001;
    end else begin
      e.res = (a == b) ? 3'b100 : (a > b) ? 3'b010 : 3'b001;
    end
    e.k = NDIG;
    for (int i = NDIG - 1; i >= 0; i--) begin
      da = a[2*i +: 2];
      db = b[2*i +: 2];
      if (i == NDIG - 1 && s) begin
        da[1] = ~da[1];
        db[1] = ~db[1];
      end
      if (da != db) begin
        e.k = NDIG - i;
        break;
      end
    end
    return e;
  endfunction

  // Drive a one-cycle start; returns at the negedge after the start edge.
  task automatic do_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic s, input bit push);
    @(negedge clk);
    aa = a; bb = b; sm = s; start = 1'b1;
    if (push) sb.push_back(model(a, b, s));
    @(negedge clk);
    start = 1'b0;
    aa = ~a; bb = a; sm = ~s;   // operand changes after capture must not matter
    chk("busy_after_start", busy, 1'b1);
  endtask

  // Wait for done (bounded), compare against the queued expectation.
  // inject_at >= 0 drives an extra start with junk operands so that edge
  // inject_at+1 samples it. chain drives a new start in the done cycle.
  task automatic wait_check(input int inject_at, input bit chain,
                            input logic [WIDTH-1:0] ca, input logic [WIDTH-1:0] cb);
    int   k;
    exp_t e;
    logic [2:0] got;
    k = 0;
    while (done !== 1'b1 && k < MAX_WAIT) begin
      if (k == inject_at) begin
        start = 1'b1; aa = 16'hFFFF; bb = 16'h0000;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    if (done !== 1'b1) begin
      chk("done_timeout", 32'(k), 32'(MAX_WAIT + 1));
      return;
    end
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    got = {EE, GG, LL};
    chk("latency_k", 32'(k), 32'(e.k));
    chk("result_eq_gt_lt", 32'(got), 32'(e.res));
    chk("busy_at_done", busy, 1'b0);
    if (chain) begin
      aa = ca; bb = cb; sm = 1'b0; start = 1'b1;
      sb.push_back(model(ca, cb, 1'b0));
      @(negedge clk);
      start = 1'b0;
      chk("chained_start_busy", busy, 1'b1);
      chk("chained_done_low", done, 1'b0);
    end else begin
      @(negedge clk);
      chk("done_one_cycle", done, 1'b0);
      chk("result_held", 32'({EE, GG, LL}), 32'(got));
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0; start = 1'b0; aa = '0; bb = '0; sm = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_res", 32'({EE, GG, LL}), 32'd0);
    rst_n = 1'b1;

    // Basic compares: equal, MSB-digit decided, LSB-digit decided, mid digit
    do_start(16'h1234, 16'h1234, 1'b0, 1'b1); wait_check(-1, 1'b0, '0, '0);
    do_start(16'h8000, 16'h7FFF, 1'b0, 1'b1); wait_check(-1, 1'b0, '0, '0);
    do_start(16'h0002, 16'h0003, 1'b0, 1'b1); wait_check(-1, 1'b0, '0, '0);
    do_start(16'h1200, 16'h1300, 1'b0, 1'b1); wait_check(-1, 1'b0, '0, '0);
    do_start(16'hFFFF, 16'h0000, 1'b0, 1'b1); wait_check(-1, 1'b0, '0, '0);

    // Asynchronous reset clears held results without waiting for a clock
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_res", 32'({EE, GG, LL}), 32'd0);
    chk("async_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Start during scan ignored; start in done cycle accepted
    do_start(16'h1234, 16'h1234, 1'b0, 1'b1);
    wait_check(2, 1'b1, 16'h8000, 16'h0001);
    wait_check(-1, 1'b0, '0, '0);

    // Reset mid-scan: aborts, no done pulse ever follows
    do_start(16'h5555, 16'h5555, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midscan_rst_busy", busy, 1'b0);
    chk("midscan_rst_out", 32'({done, EE, GG, LL}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (12) begin
        @(negedge clk);
        if (done === 1'b1) seen++;
      end
      chk("no_done_after_abort", 32'(seen), 32'd0);
    end
    do_start(16'h00FF, 16'h00FE, 1'b0, 1'b1); wait_check(-1, 1'b0, '0, '0);

    // Random operands sharing a random number of upper digits
    for (int r = 0; r < 4; r++) begin
      logic [WIDTH-1:0] ra, rb, keep;
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      keep = 16'hFFFF << (2 * $urandom_range(NDIG - 1, 0));
      rb   = (ra & keep) | (rb & ~keep);
      do_start(ra, rb, 1'b0, 1'b1); wait_check(-1, 1'b0, '0, '0);
    end

`ifdef COMPARATOR_SIGNED_EN
    do_start(16'h8000, 16'h0001, 1'b1, 1'b1); wait_check(-1, 1'b0, '0, '0);
    do_start(16'h8000, 16'h0001, 1'b0, 1'b1); wait_check(-1, 1'b0, '0, '0);
    do_start(16'hFFFE, 16'hFFFF, 1'b1, 1'b1); wait_check(-1, 1'b0, '0, '0);
`endif

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
